// File: rtl/period_meter.sv
// Measures the period and high time of sig_in in clki cycles, rising edge to rising edge,
// and flags a stall when no rising edge arrives within TIMEOUT cycles.
module period_meter #(
    parameter int              W       = 31,
    parameter longint unsigned TIMEOUT = 100000000
) (
    input  logic         clki,
    input  logic         rstn,
    input  logic         sig_in,
    output logic [W-1:0] meas_period,
    output logic [W-1:0] meas_high,
    output logic         valid,
    output logic         timeout,
    output logic         busy
);

    localparam logic [W-1:0] TIMEOUT_CNT = W'(TIMEOUT);
    localparam logic [W-1:0] CNT_ONE     = W'(1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_MEASURE = 2'd1,
        S_STALL   = 2'd2
    } state_t;

    state_t       state_q;
    logic         s1_q;
    logic         s2_q;
    logic         s3_q;
    logic         rise;
    logic         fall;
    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;
    logic [W-1:0] hi_pend_q;
    logic [W-1:0] meas_period_q;
    logic [W-1:0] meas_high_q;
    logic         valid_q;
    logic         timeout_q;
    logic         busy_q;

    // Counter increment that parks at TIMEOUT instead of wrapping.
    function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
        return (v == TIMEOUT_CNT) ? v : v + CNT_ONE;
    endfunction

    // s1/s2 resolve metastability from the foreign domain; s3 is the history for edge detection.
    always_ff @(posedge clki or negedge rstn) begin
        if (!rstn) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= sig_in;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign rise  = s2_q & ~s3_q;
    assign fall  = ~s2_q & s3_q;
    assign cnt_d = sat_inc(cnt_q);

    always_ff @(posedge clki or negedge rstn) begin
        if (!rstn) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            hi_pend_q     <= '0;
            meas_period_q <= '0;
            meas_high_q   <= '0;
            valid_q       <= 1'b0;
            timeout_q     <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    cnt_q <= '0;
                    if (rise) begin
                        state_q <= S_MEASURE;
                        busy_q  <= 1'b1;
                        cnt_q   <= CNT_ONE;
                    end
                end

                S_MEASURE: begin
                    if (fall) begin
                        hi_pend_q <= cnt_q;
                    end
                    // A rise landing exactly on the TIMEOUT count is still a valid period.
                    if (rise) begin
                        meas_period_q <= cnt_q;
                        meas_high_q   <= hi_pend_q;
                        valid_q       <= 1'b1;
                        cnt_q         <= CNT_ONE;
                    end else if (cnt_q == TIMEOUT_CNT) begin
                        state_q   <= S_STALL;
                        busy_q    <= 1'b0;
                        timeout_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end

                S_STALL: begin
                    // The period that ends the stall started at an unknown time, so it re-arms only.
                    if (rise) begin
                        state_q   <= S_MEASURE;
                        busy_q    <= 1'b1;
                        timeout_q <= 1'b0;
                        cnt_q     <= CNT_ONE;
                    end
                end

                default: begin
                    state_q   <= S_IDLE;
                    busy_q    <= 1'b0;
                    timeout_q <= 1'b0;
                    cnt_q     <= '0;
                end
            endcase
        end
    end

    assign meas_period = meas_period_q;
    assign meas_high   = meas_high_q;
    assign valid       = valid_q;
    assign timeout     = timeout_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_period_meter.sv
// Bench for period_meter: two instances (default TIMEOUT and TIMEOUT=20) checked every cycle
// against an edge-index reference model, plus literal expectations for the directed scenarios.
`timescale 1ns/10ps
module tb_period_meter;

    localparam int W = 31;

    logic         clk  = 1'b0;
    logic         rstn = 1'b0;
    logic         sig0 = 1'b0;
    logic         sig1 = 1'b0;
    logic [W-1:0] per0, hi0, per1, hi1;
    logic         vld0, to0, bsy0, vld1, to1, bsy1;

    period_meter #(.W(W)) dut0 (
        .clki(clk), .rstn(rstn), .sig_in(sig0),
        .meas_period(per0), .meas_high(hi0), .valid(vld0), .timeout(to0), .busy(bsy0)
    );

    period_meter #(.W(W), .TIMEOUT(20)) dut1 (
        .clki(clk), .rstn(rstn), .sig_in(sig1),
        .meas_period(per1), .meas_high(hi1), .valid(vld1), .timeout(to1), .busy(bsy1)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit async_chk = 1'b0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: works on the sequence of values sampled at each clock edge.
    // A rise is acted on two edges after it was first sampled; periods are edge-index differences.
    longint to_lim[2] = '{100000000, 20};
    bit     hist[2][3];
    longint edge_n = 0;
    longint lr[2], lf[2];
    int     mode[2];          // 0 unarmed, 1 measuring, 2 stalled
    bit     e_vld[2], e_to[2], e_busy[2];
    longint e_per[2], e_hi[2];
    int     m_vcnt[2] = '{0, 0};

    task automatic model_reset(input int i);
        for (int k = 0; k < 3; k++) hist[i][k] = 1'b0;
        mode[i] = 0; lr[i] = 0; lf[i] = 0;
        e_vld[i] = 1'b0; e_to[i] = 1'b0; e_busy[i] = 1'b0;
        e_per[i] = 0; e_hi[i] = 0;
    endtask

    task automatic model_edge(input int i, input bit cur);
        bit r, f;
        r = hist[i][1] && !hist[i][2];
        f = !hist[i][1] && hist[i][2];
        hist[i][2] = hist[i][1];
        hist[i][1] = hist[i][0];
        hist[i][0] = cur;
        e_vld[i] = 1'b0;
        case (mode[i])
            0: if (r) begin mode[i] = 1; lr[i] = edge_n; end
            1: begin
                if (r) begin
                    e_vld[i] = 1'b1;
                    e_per[i] = edge_n - lr[i];
                    e_hi[i]  = lf[i] - lr[i];
                    lr[i]    = edge_n;
                    m_vcnt[i]++;
                end else if (edge_n - lr[i] == to_lim[i]) begin
                    mode[i] = 2;
                    e_to[i] = 1'b1;
                end
                if (f) lf[i] = edge_n;
            end
            default: if (r) begin mode[i] = 1; lr[i] = edge_n; e_to[i] = 1'b0; end
        endcase
        e_busy[i] = (mode[i] == 1);
    endtask

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            model_reset(0);
            model_reset(1);
        end else begin
            edge_n++;
            model_edge(0, sig0);
            model_edge(1, sig1);
        end
    end

    always @(negedge clk) begin
        chk("vld0", vld0, e_vld[0]);
        chk("per0", per0, e_per[0]);
        chk("hi0",  hi0,  e_hi[0]);
        chk("to0",  to0,  e_to[0]);
        chk("busy0", bsy0, e_busy[0]);
        chk("vld1", vld1, e_vld[1]);
        chk("per1", per1, e_per[1]);
        chk("hi1",  hi1,  e_hi[1]);
        chk("to1",  to1,  e_to[1]);
        chk("busy1", bsy1, e_busy[1]);
        if (async_chk && vld0)
            chk("async_period_in_99_101", (per0 >= 99 && per0 <= 101), 1);
    end

    task automatic drive(input int which, input int p, input int h, input int n);
        for (int k = 0; k < n; k++) begin
            for (int c = 0; c < p; c++) begin
                @(posedge clk);
                #1;
                if (which == 0) sig0 = (c < h);
                else            sig1 = (c < h);
            end
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_per0"}, per0, 0); chk({tag, "_hi0"}, hi0, 0);
        chk({tag, "_vld0"}, vld0, 0); chk({tag, "_to0"}, to0, 0); chk({tag, "_busy0"}, bsy0, 0);
        chk({tag, "_per1"}, per1, 0); chk({tag, "_hi1"}, hi1, 0);
        chk({tag, "_vld1"}, vld1, 0); chk({tag, "_to1"}, to1, 0); chk({tag, "_busy1"}, bsy1, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not finish by t=%0t", $time);
        $fatal(1);
    end

    initial begin
        int base;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        @(posedge clk);
        #3 rstn = 1'b1;

        // Period 10 / high 5: first rise only arms, then one valid per period.
        drive(0, 10, 5, 1);
        chk("p10_arm_no_valid", m_vcnt[0], 0);
        chk("p10_busy_armed", bsy0, 1);
        drive(0, 10, 5, 3);
        chk("p10_valid_count", m_vcnt[0], 3);
        chk("p10_model_per", e_per[0], 10);
        chk("p10_model_hi", e_hi[0], 5);
        chk("p10_dut_per", per0, 10);
        chk("p10_dut_hi", hi0, 5);

        // Period 7 / high 2, then switch to 12 / 9.
        drive(0, 7, 2, 4);
        chk("p7_model_per", e_per[0], 7);
        chk("p7_model_hi", e_hi[0], 2);
        drive(0, 12, 9, 1);
        chk("switch_boundary_per", e_per[0], 7);
        drive(0, 12, 9, 3);
        chk("p12_model_per", e_per[0], 12);
        chk("p12_model_hi", e_hi[0], 9);
        chk("p12_dut_per", per0, 12);

        // Asynchronous input: 1000.3 ns period, edges never coincide with clock edges.
        @(posedge clk);
        #2.37;
        for (int k = 0; k < 15; k++) begin
            sig0 = 1'b1;
            #500.15;
            sig0 = 1'b0;
            #500.15;
            if (k == 0) async_chk = 1'b1;
        end
        repeat (5) @(posedge clk);
        async_chk = 1'b0;
        chk("async_last_in_99_101", (e_per[0] >= 99 && e_per[0] <= 101), 1);

        // Reset asserted mid-period, between clock edges.
        drive(0, 10, 5, 2);
        @(posedge clk);
        #1 sig0 = 1'b1;
        repeat (3) @(posedge clk);
        #3 rstn = 1'b0;
        #1;
        chk_all_zero("midrst");
        sig0 = 1'b0;
        repeat (2) @(posedge clk);
        #3 rstn = 1'b1;
        base = m_vcnt[0];
        drive(0, 10, 5, 1);
        chk("rst_first_rise_no_valid", m_vcnt[0] - base, 0);
        drive(0, 10, 5, 2);
        chk("rst_valids_after_2nd_rise", m_vcnt[0] - base, 2);

        // TIMEOUT = 20: stall, then resume.
        drive(1, 8, 4, 4);
        chk("t20_p8_count", m_vcnt[1], 3);
        chk("t20_p8_per", e_per[1], 8);
        base = m_vcnt[1];
        repeat (40) @(posedge clk);
        #1;
        chk("stall_timeout", to1, 1);
        chk("stall_busy", bsy1, 0);
        chk("stall_per_kept", per1, 8);
        chk("stall_hi_kept", hi1, 4);
        chk("stall_no_valid", m_vcnt[1] - base, 0);
        drive(1, 8, 4, 1);
        chk("resume_timeout_clear", to1, 0);
        chk("resume_busy", bsy1, 1);
        chk("resume_no_valid", m_vcnt[1] - base, 0);
        drive(1, 8, 4, 2);
        chk("resume_valids", m_vcnt[1] - base, 2);
        chk("resume_per", e_per[1], 8);

        // Period exactly TIMEOUT is measured, not timed out.
        base = m_vcnt[1];
        drive(1, 20, 10, 5);
        chk("p20_valids", m_vcnt[1] - base, 5);
        chk("p20_model_per", e_per[1], 20);
        chk("p20_dut_per", per1, 20);
        chk("p20_dut_hi", hi1, 10);
        chk("p20_no_timeout", to1, 0);

        // Randomized periods on both instances; the long ones on dut1 exercise timeouts.
        fork
            begin
                for (int k = 0; k < 30; k++) begin
                    int p, h;
                    p = $urandom_range(40, 2);
                    h = $urandom_range(p - 1, 1);
                    drive(0, p, h, 1 + $urandom_range(2, 0));
                end
            end
            begin
                for (int k = 0; k < 25; k++) begin
                    int p, h;
                    p = $urandom_range(26, 2);
                    h = $urandom_range(p - 1, 1);
                    drive(1, p, h, 1 + $urandom_range(1, 0));
                    if ($urandom_range(3, 0) == 0) repeat ($urandom_range(30, 5)) @(posedge clk);
                end
            end
        join

        repeat (5) @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
